vram_arbiter: RTL
=================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15, width of the VRAM word address.
REQ-002 Parameter DATA_W, default 8, width of the VRAM data word.
REQ-003 Parameter MAX_WAIT, default 15, number of consecutive denied CPU cycles before the CPU is forced a slot; legal range 1..255.
REQ-004 dot_clk  input  1  sole clock; all logic is clocked on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 vid_req  input  1  video fetch request, sampled every edge.
REQ-007 vid_addr  input  ADDR_W  video fetch address, valid with vid_req.
REQ-008 vid_gnt  output  1  combinational; high when the video request present this cycle is accepted at the next edge.
REQ-009 vid_valid  output  1  one-cycle pulse; vid_data holds fetched data.
REQ-010 vid_data  output  DATA_W  video read data.
REQ-011 cpu_req  input  1  CPU access request, held high until cpu_ack.
REQ-012 cpu_we  input  1  1 = write, 0 = read; stable while cpu_req high.
REQ-013 cpu_addr  input  ADDR_W  CPU address; stable while cpu_req high.
REQ-014 cpu_wdata  input  DATA_W  CPU write data; stable while cpu_req high.
REQ-015 cpu_ack  output  1  one-cycle pulse marking CPU access completion.
REQ-016 cpu_rdata  output  DATA_W  CPU read data, valid with cpu_ack on reads.
REQ-017 mem_addr  output  ADDR_W  registered address to the synchronous single-port VRAM.
REQ-018 mem_we  output  1  registered write enable to VRAM.
REQ-019 mem_wdata  output  DATA_W  registered write data to VRAM.
REQ-020 mem_rdata  input  DATA_W  VRAM read data, valid the cycle after the VRAM samples mem_addr.

Function
REQ-021 Each edge issues at most one access; winner registered into mem_addr/mem_we/mem_wdata and a 2-stage tag pipeline (IDLE, VID, CPU_RD, CPU_WR).
REQ-022 Arbitration per cycle: if CPU forced (REQ-025) and cpu_req and no CPU access in flight -> CPU; else vid_req -> video; else eligible cpu_req -> CPU; else IDLE (mem_we=0, mem_addr holds).
REQ-023 CPU eligible only when no CPU access is in the tag pipeline; a held cpu_req is never issued twice.
REQ-024 Latency: access issued at edge k; vid_valid or cpu_ack pulses high for exactly the cycle after edge k+2; data captured from mem_rdata at edge k+2.
REQ-025 Wait counter (8 bit): increments each edge cpu_req is high, eligible and not issued; clears on CPU issue or cpu_req low; saturates at MAX_WAIT; CPU forced when counter == MAX_WAIT.
REQ-026 When CPU forced and vid_req high, vid_gnt=0; the video requester re-presents next cycle.
REQ-027 Writes: mem_we=1 only in the issue cycle of a CPU write; cpu_ack still at k+2; cpu_rdata unchanged on write ack.
REQ-028 vid_data/cpu_rdata hold last captured value between pulses.
REQ-029 vid_valid and cpu_ack never high in the same cycle for the same slot; back-to-back video issues yield vid_valid on consecutive cycles.
REQ-030 cpu_req dropped before ack (protocol violation): in-flight access completes and acks; no new issue.

Reset
REQ-031 reset_n low asynchronously forces: vid_valid=0, cpu_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, vid_data=0, cpu_rdata=0, wait counter=0, tag pipeline=IDLE.
REQ-032 Accesses in flight at reset are discarded; no pulse after release; first issue at first edge with reset_n high.

Verification
REQ-033 vid_req only, vid_addr=0x0010, RAM[0x0010]=0xA5 -> vid_gnt=1, vid_valid one cycle after edge k+2, vid_data=0xA5.
REQ-034 CPU write 0x3C to 0x0100, then CPU read 0x0100, no video -> mem_we=1 one cycle, cpu_ack twice, second cpu_rdata=0x3C.
REQ-035 vid_req held continuously, cpu_req read held, MAX_WAIT=15 -> CPU issued on 16th edge, vid_gnt=0 that cycle only, cpu_ack two cycles later, video resumes.
REQ-036 vid_req and cpu_req rise same cycle, counter 0 -> video issued first, CPU issued next idle or forced slot.
REQ-037 reset_n pulsed low one cycle after CPU read issue -> no cpu_ack, all outputs at REQ-031 values, held cpu_req re-issued after release and acked once.
REQ-038 Randomised vid_req/cpu_req traffic against a reference memory model -> every vid_valid/cpu_rdata matches model, no CPU wait exceeds MAX_WAIT+1 cycles.

Source files
------------

// File: rtl/vram_arbiter.sv
// Shares one synchronous single-port VRAM between a video fetcher and a CPU.
// Video has priority. A CPU that has been starved for MAX_WAIT cycles is forced the next slot.
module vram_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic              dot_clk,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // tag        | meaning
    // TAG_IDLE   | no access occupies this pipeline slot
    // TAG_VID    | video fetch, completes with vid_valid
    // TAG_CPU_RD | CPU read, completes with cpu_ack and new cpu_rdata
    // TAG_CPU_WR | CPU write, completes with cpu_ack only
    typedef enum logic [1:0] {
        TAG_IDLE   = 2'd0,
        TAG_VID    = 2'd1,
        TAG_CPU_RD = 2'd2,
        TAG_CPU_WR = 2'd3
    } tag_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    tag_t       r_tag1;
    tag_t       r_tag2;
    tag_t       w_issue;
    logic [7:0] r_wait;
    logic [7:0] w_wait_next;
    logic       w_cpu_busy;
    logic       w_cpu_elig;
    logic       w_force;
    logic       w_issue_cpu;

    // The ack cycle also counts as busy, because the CPU still holds cpu_req while it sees the ack.
    always_comb begin
        w_cpu_busy  = (r_tag1 == TAG_CPU_RD) || (r_tag1 == TAG_CPU_WR) ||
                      (r_tag2 == TAG_CPU_RD) || (r_tag2 == TAG_CPU_WR) || cpu_ack;
        w_cpu_elig  = cpu_req && !w_cpu_busy;
        w_force     = w_cpu_elig && (r_wait == WAIT_LIMIT);
        w_issue     = TAG_IDLE;
        w_issue_cpu = 1'b0;
        if (w_force || (!vid_req && w_cpu_elig)) begin
            w_issue_cpu = 1'b1;
            if (cpu_we) w_issue = TAG_CPU_WR;
            else        w_issue = TAG_CPU_RD;
        end else if (vid_req) begin
            w_issue = TAG_VID;
        end
        vid_gnt     = vid_req && !w_force;
        w_wait_next = r_wait;
        if (!cpu_req || w_issue_cpu)
            w_wait_next = 8'd0;
        else if (w_cpu_elig && (r_wait != WAIT_LIMIT))
            w_wait_next = r_wait + 8'd1;
    end

    always_ff @(posedge dot_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag1    <= TAG_IDLE;
            r_tag2    <= TAG_IDLE;
            r_wait    <= 8'd0;
            vid_valid <= 1'b0;
            cpu_ack   <= 1'b0;
            vid_data  <= '0;
            cpu_rdata <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            r_tag1    <= w_issue;
            r_tag2    <= r_tag1;
            r_wait    <= w_wait_next;
            vid_valid <= 1'b0;
            cpu_ack   <= 1'b0;
            mem_we    <= (w_issue == TAG_CPU_WR);

            unique case (w_issue)
                TAG_VID:    mem_addr <= vid_addr;
                TAG_CPU_RD: mem_addr <= cpu_addr;
                TAG_CPU_WR: begin
                    mem_addr  <= cpu_addr;
                    mem_wdata <= cpu_wdata;
                end
                default: ;
            endcase

            // The second tag stage lines up with the read data the VRAM returns.
            unique case (r_tag2)
                TAG_VID: begin
                    vid_valid <= 1'b1;
                    vid_data  <= mem_rdata;
                end
                TAG_CPU_RD: begin
                    cpu_ack   <= 1'b1;
                    cpu_rdata <= mem_rdata;
                end
                TAG_CPU_WR: cpu_ack <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule
